// File: rtl/turkey_gun_ctrl.sv
// Turkey gun aim controller: per-axis button FSMs step gun_h/gun_v once per 4 ms tick; outputs registered, update one cycle after tick/recenter; no backpressure.
// Define TURKEY_GUN_ACCEL_EN to enable hold-time acceleration (step 2 after HOLD_MED ticks, 4 after HOLD_FAST); otherwise step is always 1.
module turkey_gun_ctrl #(
    parameter logic [5:0] GUN_MIN    = 6'd0,
    parameter logic [5:0] GUN_MAX    = 6'd63,
    parameter logic [5:0] GUN_CENTER = 6'd32,
    parameter int         HOLD_MED   = 8,
    parameter int         HOLD_FAST  = 24
) (
    input  logic       clock_12,
    input  logic       reset,
    input  logic       cnt_4ms,
    input  logic       joy_up,
    input  logic       joy_down,
    input  logic       joy_left,
    input  logic       joy_right,
    input  logic       recenter,
    output logic [5:0] gun_h,
    output logic [5:0] gun_v,
    output logic       moving
);

    typedef enum logic [1:0] {IDLE, MOVE_SLOW, MOVE_MED, MOVE_FAST} axis_state_t;

    if (HOLD_FAST <= HOLD_MED) begin : g_hold_order_invalid
        $error("HOLD_FAST must be greater than HOLD_MED");
    end

    // Axis index 0 is horizontal, 1 is vertical.
    axis_state_t       state     [2];
    axis_state_t       state_n   [2];
    logic [7:0]        hold      [2];
    logic [7:0]        hold_n    [2];
    logic              dir_neg   [2];
    logic              dir_neg_n [2];
    logic [5:0]        pos       [2];
    logic [5:0]        pos_n     [2];
    logic signed [7:0] delta     [2];
    logic signed [7:0] sum       [2];

    logic       cnt_q;
    logic       tick;
    logic       moving_n;
    logic [1:0] plus;
    logic [1:0] minus;
    logic [1:0] dir_nz;
    logic [1:0] dir_neg_in;

    assign plus       = {joy_down, joy_right};
    assign minus      = {joy_up, joy_left};
    assign dir_nz     = plus ^ minus;
    assign dir_neg_in = minus & ~plus;

    assign gun_h = pos[0];
    assign gun_v = pos[1];

    always_ff @(posedge clock_12 or posedge reset) begin
        if (reset) begin
            cnt_q  <= 1'b1;
            tick   <= 1'b0;
            moving <= 1'b0;
            for (int a = 0; a < 2; a++) begin
                state[a]   <= IDLE;
                hold[a]    <= 8'd0;
                dir_neg[a] <= 1'b0;
                pos[a]     <= GUN_CENTER;
            end
        end else begin
            cnt_q  <= cnt_4ms;
            tick   <= cnt_4ms & ~cnt_q;
            moving <= moving_n;
            for (int a = 0; a < 2; a++) begin
                state[a]   <= state_n[a];
                hold[a]    <= hold_n[a];
                dir_neg[a] <= dir_neg_n[a];
                pos[a]     <= pos_n[a];
            end
        end
    end

    always_comb begin
        for (int a = 0; a < 2; a++) begin
            state_n[a]   = state[a];
            hold_n[a]    = hold[a];
            dir_neg_n[a] = dir_neg[a];
            pos_n[a]     = pos[a];
            delta[a]     = 8'sd0;
            sum[a]       = 8'sd0;
            if (recenter) begin
                state_n[a]   = IDLE;
                hold_n[a]    = 8'd0;
                dir_neg_n[a] = 1'b0;
                pos_n[a]     = GUN_CENTER;
            end else if (tick) begin
                if (state[a] == IDLE) begin
                    if (dir_nz[a]) begin
                        state_n[a]   = MOVE_SLOW;
                        hold_n[a]    = 8'd1;
                        dir_neg_n[a] = dir_neg_in[a];
                    end
                end else if (!dir_nz[a] || (dir_neg_in[a] != dir_neg[a])) begin
                    // Release or reversal parks the axis for one tick without stepping.
                    state_n[a] = IDLE;
                    hold_n[a]  = 8'd0;
                end else begin
                    hold_n[a] = (hold[a] == 8'hFF) ? 8'hFF : hold[a] + 8'd1;
`ifdef TURKEY_GUN_ACCEL_EN
                    if (int'(hold_n[a]) >= HOLD_FAST)
                        state_n[a] = MOVE_FAST;
                    else if (int'(hold_n[a]) >= HOLD_MED)
                        state_n[a] = MOVE_MED;
                    else
                        state_n[a] = MOVE_SLOW;
`else
                    state_n[a] = MOVE_SLOW;
`endif
                end
                case (state_n[a])
                    MOVE_SLOW: delta[a] = 8'sd1;
                    MOVE_MED:  delta[a] = 8'sd2;
                    MOVE_FAST: delta[a] = 8'sd4;
                    default:   delta[a] = 8'sd0;
                endcase
                if (dir_neg_n[a])
                    delta[a] = -delta[a];
                // Extra headroom bit keeps GUN_MAX + 4 from wrapping before the clamp.
                sum[a] = $signed({2'b00, pos[a]}) + delta[a];
                if (sum[a] > $signed({2'b00, GUN_MAX}))
                    pos_n[a] = GUN_MAX;
                else if (sum[a] < $signed({2'b00, GUN_MIN}))
                    pos_n[a] = GUN_MIN;
                else
                    pos_n[a] = sum[a][5:0];
            end
        end
        moving_n = (state_n[0] != IDLE) || (state_n[1] != IDLE);
    end

endmodule

// File: tb/tb_turkey_gun_ctrl.sv
// Directed bench for turkey_gun_ctrl: tick-by-tick vector table plus hand-written corner sequences.
module tb_turkey_gun_ctrl;

    logic       clock_12 = 1'b0;
    logic       reset    = 1'b1;
    logic       cnt_4ms  = 1'b0;
    logic       joy_up   = 1'b0;
    logic       joy_down = 1'b0;
    logic       joy_left = 1'b0;
    logic       joy_right = 1'b0;
    logic       recenter = 1'b0;
    logic [5:0] gun_h;
    logic [5:0] gun_v;
    logic       moving;

    int errors = 0;
    int checks = 0;

    turkey_gun_ctrl dut (
        .clock_12 (clock_12),
        .reset    (reset),
        .cnt_4ms  (cnt_4ms),
        .joy_up   (joy_up),
        .joy_down (joy_down),
        .joy_left (joy_left),
        .joy_right(joy_right),
        .recenter (recenter),
        .gun_h    (gun_h),
        .gun_v    (gun_v),
        .moving   (moving)
    );

    always #5 clock_12 = ~clock_12;

    typedef struct {
        logic up;
        logic down;
        logic left;
        logic right;
        int   h;
        int   v;
        int   mv;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int eh, input int ev, input int em);
        check({name, ".gun_h"}, int'(gun_h), eh);
        check({name, ".gun_v"}, int'(gun_v), ev);
        check({name, ".moving"}, int'(moving), em);
    endtask

    task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
        joy_up    = u;
        joy_down  = d;
        joy_left  = l;
        joy_right = r;
    endtask

    // Rising cnt_4ms -> tick strobe next cycle -> position update on the following edge.
    task automatic do_tick();
        @(negedge clock_12) cnt_4ms = 1'b1;
        @(negedge clock_12) cnt_4ms = 1'b0;
        @(negedge clock_12);
    endtask

    task automatic tick_recenter();
        @(negedge clock_12) cnt_4ms = 1'b1;
        @(negedge clock_12) begin
            cnt_4ms  = 1'b0;
            recenter = 1'b1;
        end
        @(negedge clock_12) recenter = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock_12);
        reset    = 1'b1;
        cnt_4ms  = 1'b0;
        recenter = 1'b0;
        set_btn(0, 0, 0, 0);
        @(negedge clock_12);
        check_out("in_reset", 32, 32, 0);
        reset = 1'b0;
        @(negedge clock_12);
    endtask

    initial begin
        tbl[0]  = '{up: 0, down: 0, left: 0, right: 0, h: 32, v: 32, mv: 0};
        tbl[1]  = '{up: 0, down: 0, left: 0, right: 1, h: 33, v: 32, mv: 1};
        tbl[2]  = '{up: 0, down: 0, left: 0, right: 1, h: 34, v: 32, mv: 1};
        tbl[3]  = '{up: 0, down: 0, left: 1, right: 1, h: 34, v: 32, mv: 0};
        tbl[4]  = '{up: 0, down: 0, left: 1, right: 1, h: 34, v: 32, mv: 0};
        tbl[5]  = '{up: 0, down: 0, left: 1, right: 0, h: 33, v: 32, mv: 1};
        tbl[6]  = '{up: 1, down: 0, left: 0, right: 0, h: 33, v: 31, mv: 1};
        tbl[7]  = '{up: 1, down: 0, left: 0, right: 1, h: 34, v: 30, mv: 1};
        tbl[8]  = '{up: 0, down: 1, left: 1, right: 0, h: 34, v: 30, mv: 0};
        tbl[9]  = '{up: 0, down: 1, left: 1, right: 0, h: 33, v: 31, mv: 1};
        tbl[10] = '{up: 0, down: 0, left: 0, right: 0, h: 33, v: 31, mv: 0};

        // Reset release with idle inputs for 10 ticks
        do_reset();
        for (int t = 1; t <= 10; t++) begin
            do_tick();
            if (t == 1 || t == 10) check_out($sformatf("idle_t%0d", t), 32, 32, 0);
        end

        // Vector table, one tick per row
        for (int i = 0; i < 11; i++) begin
            set_btn(tbl[i].up, tbl[i].down, tbl[i].left, tbl[i].right);
            do_tick();
            check_out($sformatf("vec%0d", i), tbl[i].h, tbl[i].v, tbl[i].mv);
        end

        // Right held: acceleration and upper clamp
        do_reset();
        set_btn(0, 0, 0, 1);
        for (int t = 1; t <= 34; t++) begin
            do_tick();
            if (t == 7) check_out("right_t7", 39, 32, 1);
`ifdef TURKEY_GUN_ACCEL_EN
            if (t == 20) check_out("right_t20", 63, 32, 1);
            if (t == 30) check_out("right_t30", 63, 32, 1);
`else
            if (t == 20) check_out("right_t20", 52, 32, 1);
            if (t == 30) check_out("right_t30", 62, 32, 1);
`endif
            if (t == 34) check_out("right_t34", 63, 32, 1);
        end

        // Left held: lower clamp, axis stays moving
        do_reset();
        set_btn(0, 0, 1, 0);
        for (int t = 1; t <= 34; t++) do_tick();
        check_out("left_clamp", 0, 32, 1);

        // Opposing buttons cancel
        do_reset();
        set_btn(0, 0, 1, 1);
        for (int t = 1; t <= 5; t++) begin
            do_tick();
            check_out($sformatf("both_lr_t%0d", t), 32, 32, 0);
        end

        // Up 3 ticks, then reversal parks for a tick before moving down
        do_reset();
        set_btn(1, 0, 0, 0);
        for (int t = 1; t <= 3; t++) do_tick();
        check_out("up_t3", 32, 29, 1);
        set_btn(0, 1, 0, 0);
        do_tick();
        check_out("rev_t4", 32, 29, 0);
        do_tick();
        check_out("rev_t5", 32, 30, 1);

        // Recenter coincident with tick while moving down
        do_reset();
        set_btn(0, 1, 0, 0);
        for (int t = 1; t <= 18; t++) do_tick();
`ifdef TURKEY_GUN_ACCEL_EN
        check_out("down_t18", 32, 61, 1);
`else
        check_out("down_t18", 32, 50, 1);
`endif
        tick_recenter();
        check_out("recenter_tick", 32, 32, 0);
        do_tick();
        check_out("after_recenter", 32, 33, 1);
        @(negedge clock_12) recenter = 1'b1;
        @(negedge clock_12) recenter = 1'b0;
        check_out("recenter_alone", 32, 32, 0);

        // Button pressed and released between ticks is ignored
        do_reset();
        @(negedge clock_12) joy_right = 1'b1;
        repeat (3) @(negedge clock_12);
        joy_right = 1'b0;
        do_tick();
        check_out("between_ticks", 32, 32, 0);

        // cnt_4ms already high at reset release gives no tick
        @(negedge clock_12);
        reset = 1'b1;
        cnt_4ms = 1'b1;
        set_btn(0, 0, 0, 1);
        @(negedge clock_12) reset = 1'b0;
        repeat (4) @(negedge clock_12);
        check_out("no_tick_on_release", 32, 32, 0);
        cnt_4ms = 1'b0;
        set_btn(0, 0, 0, 0);

        // Asynchronous reset mid-motion
        do_reset();
        set_btn(1, 0, 0, 1);
        for (int t = 1; t <= 3; t++) do_tick();
        check_out("pre_async", 35, 29, 1);
        @(posedge clock_12);
        #2 reset = 1'b1;
        #1 check_out("async_reset", 32, 32, 0);
        @(negedge clock_12) reset = 1'b0;
        set_btn(0, 0, 0, 0);
        repeat (2) @(negedge clock_12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
